uigr_led_arbiter: RTL and testbench

UIGR_LED_ARBITER -- requirements
Module: uigr_led_arbiter

---
 rtl/uigr_pkg.sv | 36 +++
 rtl/uigr_req_slot.sv | 47 ++++
 rtl/uigr_led_arbiter.sv | 133 +++++++++++++
 tb/tb_uigr_led_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uigr_pkg.sv
// Shared definitions for the LED arbiter: pattern codes, port indices, FSM encoding.
package uigr_pkg;

  localparam logic [3:0] PAT_NONE        = 4'd0;
  localparam logic [3:0] PAT_50HZ        = 4'd1;
  localparam logic [3:0] PAT_60HZ        = 4'd2;
  localparam logic [3:0] PAT_CARTRIDGE   = 4'd3;
  localparam logic [3:0] PAT_TIMEOUT_ON  = 4'd4;
  localparam logic [3:0] PAT_TIMEOUT_OFF = 4'd5;
  localparam logic [3:0] PAT_D4_ON       = 4'd6;
  localparam logic [3:0] PAT_D4_OFF      = 4'd7;
  localparam logic [3:0] PAT_LOCKED      = 4'd8;
  localparam logic [3:0] PAT_UNLOCKED    = 4'd10;

  localparam int NUM_PORTS   = 3;
  localparam int PORT_RST    = 0;
  localparam int PORT_PAD    = 1;
  localparam int PORT_STATUS = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_PLAY  = 3'd3,
    ST_GAP   = 3'd4
  } arb_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [2:0] lowest_onehot(input logic [2:0] v);
    return v & (~v + 3'd1);
  endfunction

endpackage

// File: rtl/uigr_req_slot.sv
// One requester slot: latches pattern, holds pending, acks one cycle after req.
// A new nonzero request always beats a same-cycle clear so it is never lost.
module uigr_req_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [3:0] req_pattern,
  input  logic       clr,
  output logic       ack,
  output logic       pending,
  output logic [3:0] pattern
);
  import uigr_pkg::*;

  logic       ack_q, ack_d;
  logic       pending_q, pending_d;
  logic [3:0] pattern_q, pattern_d;

  always_comb begin
    ack_d     = req;
    pending_d = pending_q;
    pattern_d = pattern_q;
    if (req && (req_pattern != PAT_NONE)) begin
      pending_d = 1'b1;
      pattern_d = req_pattern;
    end else if (clr) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q     <= 1'b0;
      pending_q <= 1'b0;
      pattern_q <= PAT_NONE;
    end else begin
      ack_q     <= ack_d;
      pending_q <= pending_d;
      pattern_q <= pattern_d;
    end
  end

  assign ack     = ack_q;
  assign pending = pending_q;
  assign pattern = pattern_q;

endmodule

// File: rtl/uigr_led_arbiter.sv
// LED pattern arbiter: three request slots share one LED driver, lowest port wins, port 0 preempts.
// Idle req at T gives drv_rst at T+2; ports 1/2 wait for the current pattern plus an idle gap.
module uigr_led_arbiter #(
  parameter int GAP_TICKS     = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [11:0] req_pattern,
  output logic [2:0]  ack,
  output logic [2:0]  pending,
  output logic [2:0]  active,
  output logic [3:0]  drv_pattern,
  output logic        drv_rst,
  input  logic        drv_busy
);
  import uigr_pkg::*;

  localparam int CNT_W = $clog2(max_int(GAP_TICKS, START_TIMEOUT) + 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       active_q, active_d;
  logic [3:0]       drv_pattern_q, drv_pattern_d;
  logic             drv_rst_q, drv_rst_d;

  logic [2:0] slot_clr;
  logic [3:0] slot_pat [NUM_PORTS];
  logic       load_en;
  logic [2:0] load_sel;
  logic       preempt;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_slot
    uigr_req_slot u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req[g]),
      .req_pattern (req_pattern[4*g +: 4]),
      .clr         (slot_clr[g]),
      .ack         (ack[g]),
      .pending     (pending[g]),
      .pattern     (slot_pat[g])
    );
  end

  // The winner's pending bit drops at the end of its LOAD cycle.
  assign slot_clr = (state_q == ST_LOAD) ? active_q : 3'b000;
  assign preempt  = pending[PORT_RST] && !active_q[PORT_RST];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    active_d      = active_q;
    drv_pattern_d = drv_pattern_q;
    drv_rst_d     = 1'b0;
    load_en       = 1'b0;
    load_sel      = 3'b000;

    case (state_q)
      ST_IDLE: begin
        if (|pending) begin
          load_en  = 1'b1;
          load_sel = lowest_onehot(pending);
        end
      end
      ST_LOAD: state_d = ST_START;
      ST_START: begin
        if (preempt) begin
          load_en  = 1'b1;
          load_sel = 3'b001;
        end else if (drv_busy) begin
          state_d = ST_PLAY;
        end else if (int'(cnt_q) + 1 >= START_TIMEOUT) begin
          state_d = ST_GAP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PLAY: begin
        if (preempt) begin
          load_en  = 1'b1;
          load_sel = 3'b001;
        end else if (!drv_busy) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (drv_busy) begin
          cnt_d = '0;
        end else if (int'(cnt_q) + 1 >= GAP_TICKS) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_en) begin
      state_d   = ST_LOAD;
      active_d  = load_sel;
      drv_rst_d = 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (load_sel[i]) drv_pattern_d = slot_pat[i];
      end
    end

    if (state_d != state_q) cnt_d = '0;
    if ((state_d == ST_GAP) || (state_d == ST_IDLE)) active_d = 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      active_q      <= 3'b000;
      drv_pattern_q <= PAT_NONE;
      drv_rst_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      active_q      <= active_d;
      drv_pattern_q <= drv_pattern_d;
      drv_rst_q     <= drv_rst_d;
    end
  end

  assign active      = active_q;
  assign drv_pattern = drv_pattern_q;
  assign drv_rst     = drv_rst_q;

endmodule

// File: tb/tb_uigr_led_arbiter.sv
// Directed bench for uigr_led_arbiter: vector table plus preemption, timeout and reset sequences.
module tb_uigr_led_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [11:0] req_pattern = 12'h000;
  logic        drv_busy = 1'b0;
  logic [2:0]  ack, pending, active;
  logic [3:0]  drv_pattern;
  logic        drv_rst;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uigr_led_arbiter #(.GAP_TICKS(4), .START_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_pattern (req_pattern),
    .ack         (ack),
    .pending     (pending),
    .active      (active),
    .drv_pattern (drv_pattern),
    .drv_rst     (drv_rst),
    .drv_busy    (drv_busy)
  );

  typedef struct {
    logic [2:0]  req;
    logic [11:0] pat;
    logic        busy;
    logic [2:0]  e_ack;
    logic [2:0]  e_pend;
    logic [2:0]  e_act;
    logic        e_rst;
    logic [3:0]  e_pat;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] pk(input logic [3:0] p2, input logic [3:0] p1, input logic [3:0] p0);
    return {p2, p1, p0};
  endfunction

  task automatic add(input logic [2:0] r, input logic [11:0] p, input logic b,
                     input logic [2:0] ea, input logic [2:0] ep, input logic [2:0] eact,
                     input logic er, input logic [3:0] epat);
    vec_t v;
    v.req = r; v.pat = p; v.busy = b;
    v.e_ack = ea; v.e_pend = ep; v.e_act = eact; v.e_rst = er; v.e_pat = epat;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx);
    chk({tag, "_ack"},  idx, 16'(ack),         16'd0);
    chk({tag, "_pend"}, idx, 16'(pending),     16'd0);
    chk({tag, "_act"},  idx, 16'(active),      16'd0);
    chk({tag, "_rst"},  idx, 16'(drv_rst),     16'd0);
    chk({tag, "_pat"},  idx, 16'(drv_pattern), 16'd0);
  endtask

  initial begin
    int nr;
    int first;

    // Single play, two simultaneous requests, same-cycle re-request during LOAD, gap restart, zero pattern.
    add(3'b010, pk(4'd0, 4'd2, 4'd0), 1'b0, 3'b010, 3'b010, 3'b000, 1'b0, 4'd0);
    add(3'b000, 12'h000, 1'b0, 3'b000, 3'b010, 3'b010, 1'b1, 4'd2);
    add(3'b000, 12'h000, 1'b0, 3'b000, 3'b000, 3'b010, 1'b0, 4'd2);
    repeat (10) add(3'b000, 12'h000, 1'b1, 3'b000, 3'b000, 3'b010, 1'b0, 4'd2);
    add(3'b000, 12'h000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 4'd2);
    add(3'b110, pk(4'd4, 4'd3, 4'd0), 1'b0, 3'b110, 3'b110, 3'b000, 1'b0, 4'd2);
    repeat (3) add(3'b000, 12'h000, 1'b0, 3'b000, 3'b110, 3'b000, 1'b0, 4'd2);
    add(3'b000, 12'h000, 1'b0, 3'b000, 3'b110, 3'b010, 1'b1, 4'd3);
    add(3'b010, pk(4'd0, 4'd5, 4'd0), 1'b0, 3'b010, 3'b110, 3'b010, 1'b0, 4'd3);
    add(3'b010, pk(4'd0, 4'd7, 4'd0), 1'b1, 3'b010, 3'b110, 3'b010, 1'b0, 4'd3);
    add(3'b000, 12'h000, 1'b1, 3'b000, 3'b110, 3'b010, 1'b0, 4'd3);
    add(3'b000, 12'h000, 1'b0, 3'b000, 3'b110, 3'b000, 1'b0, 4'd3);
    add(3'b000, 12'h000, 1'b1, 3'b000, 3'b110, 3'b000, 1'b0, 4'd3);
    repeat (4) add(3'b000, 12'h000, 1'b0, 3'b000, 3'b110, 3'b000, 1'b0, 4'd3);
    add(3'b000, 12'h000, 1'b0, 3'b000, 3'b110, 3'b010, 1'b1, 4'd7);
    add(3'b000, 12'h000, 1'b0, 3'b000, 3'b100, 3'b010, 1'b0, 4'd7);
    add(3'b000, 12'h000, 1'b1, 3'b000, 3'b100, 3'b010, 1'b0, 4'd7);
    add(3'b000, 12'h000, 1'b0, 3'b000, 3'b100, 3'b000, 1'b0, 4'd7);
    add(3'b000, 12'h000, 1'b0, 3'b000, 3'b100, 3'b000, 1'b0, 4'd7);
    add(3'b001, 12'h000, 1'b0, 3'b001, 3'b100, 3'b000, 1'b0, 4'd7);
    repeat (2) add(3'b000, 12'h000, 1'b0, 3'b000, 3'b100, 3'b000, 1'b0, 4'd7);
    add(3'b000, 12'h000, 1'b0, 3'b000, 3'b100, 3'b100, 1'b1, 4'd4);
    add(3'b000, 12'h000, 1'b0, 3'b000, 3'b000, 3'b100, 1'b0, 4'd4);
    add(3'b000, 12'h000, 1'b1, 3'b000, 3'b000, 3'b100, 1'b0, 4'd4);
    repeat (5) add(3'b000, 12'h000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 4'd4);

    // Reset state
    #2;
    chk_all("reset", 0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      req         = vecs[i].req;
      req_pattern = vecs[i].pat;
      drv_busy    = vecs[i].busy;
      tick();
      chk("tbl_ack",  i, 16'(ack),         16'(vecs[i].e_ack));
      chk("tbl_pend", i, 16'(pending),     16'(vecs[i].e_pend));
      chk("tbl_act",  i, 16'(active),      16'(vecs[i].e_act));
      chk("tbl_rst",  i, 16'(drv_rst),     16'(vecs[i].e_rst));
      chk("tbl_pat",  i, 16'(drv_pattern), 16'(vecs[i].e_pat));
    end
    req = 3'b000; req_pattern = 12'h000; drv_busy = 1'b0;

    // Port 0 preempts a playing port 1, which is then dropped
    req = 3'b010; req_pattern = pk(4'd0, 4'd2, 4'd0);
    tick();
    req = 3'b000;
    tick();
    chk("pre_load_rst", 0, 16'(drv_rst), 16'd1);
    chk("pre_load_act", 0, 16'(active), 16'b010);
    tick();
    drv_busy = 1'b1;
    tick();
    tick();
    req = 3'b001; req_pattern = pk(4'd0, 4'd0, 4'd1);
    tick();
    req = 3'b000;
    chk("pre_ack", 0, 16'(ack), 16'b001);
    chk("pre_pend", 0, 16'(pending), 16'b001);
    tick();
    chk("pre_rst", 0, 16'(drv_rst), 16'd1);
    chk("pre_pat", 0, 16'(drv_pattern), 16'd1);
    chk("pre_act", 0, 16'(active), 16'b001);
    tick();
    chk("pre_pend_clr", 0, 16'(pending), 16'b000);
    chk("pre_rst_once", 0, 16'(drv_rst), 16'd0);
    tick();
    drv_busy = 1'b0;
    nr = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (drv_rst) nr++;
    end
    chk("pre_no_replay", 0, 16'(nr), 16'd0);
    chk("pre_idle_act", 0, 16'(active), 16'b000);

    // Driver never goes busy: START times out after 16 cycles
    req = 3'b100; req_pattern = pk(4'd6, 4'd0, 4'd0);
    tick();
    req = 3'b000;
    tick();
    chk("to_rst", 0, 16'(drv_rst), 16'd1);
    chk("to_pat", 0, 16'(drv_pattern), 16'd6);
    first = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (active == 3'b000 && first == 0) first = k;
    end
    chk("to_start_len", 0, 16'(first), 16'd17);
    req = 3'b001; req_pattern = 12'h000;
    tick();
    req = 3'b000;
    chk("zero_ack", 0, 16'(ack), 16'b001);
    chk("zero_pend", 0, 16'(pending), 16'b000);
    tick();
    tick();
    chk("zero_no_rst", 0, 16'(drv_rst), 16'd0);

    // Reset during PLAY, then the first request after release
    req = 3'b010; req_pattern = pk(4'd0, 4'd2, 4'd0);
    tick();
    req = 3'b000;
    tick();
    tick();
    drv_busy = 1'b1;
    tick();
    req = 3'b100; req_pattern = pk(4'd8, 4'd0, 4'd0);
    tick();
    req = 3'b000;
    chk("rp_pend_before", 0, 16'(pending), 16'b100);
    rst_n = 1'b0;
    #1;
    chk_all("rst_play", 0);
    drv_busy = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    req = 3'b010; req_pattern = pk(4'd0, 4'd2, 4'd0);
    tick();
    req = 3'b000;
    chk("rel_ack", 0, 16'(ack), 16'b010);
    chk("rel_pend", 0, 16'(pending), 16'b010);
    tick();
    chk("rel_rst", 0, 16'(drv_rst), 16'd1);
    chk("rel_pat", 0, 16'(drv_pattern), 16'd2);
    chk("rel_act", 0, 16'(active), 16'b010);

    // Reset in the LOAD cycle kills the drv_rst pulse at once
    rst_n = 1'b0;
    #1;
    chk_all("rst_load", 0);
    tick();
    rst_n = 1'b1;
    nr = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (drv_rst) nr++;
    end
    chk("rst_load_abandon", 0, 16'(nr), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
